dyt_alu_arb: RTL and testbench

DYT_ALU_ARB -- requirements
Module: dyt_alu_arb

---
 rtl/common_types.sv | 14 +
 rtl/dyt_alu_if.sv | 15 +
 rtl/dyt_alu.sv | 33 +++
 rtl/dyt_alu_arb.sv | 89 ++++++++
 tb/tb_dyt_alu_arb.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/common_types.sv
// Shared datapath types: machine word width and the ALU operation set.
package common_types;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } aluop_t;

endpackage

// File: rtl/dyt_alu_if.sv
// Bundle between an ALU and the single client that drives its operands.
interface dyt_alu_if;
  import common_types::*;

  aluop_t            op;
  logic [WORD_W-1:0] a;
  logic [WORD_W-1:0] b;
  logic [WORD_W-1:0] res;
  logic              zero;
  logic              neg;
  logic              ovf;

  modport alu    (input op, a, b, output res, zero, neg, ovf);
  modport client (output op, a, b, input res, zero, neg, ovf);
endinterface

// File: rtl/dyt_alu.sv
// Purely combinational ALU: result plus zero/negative/signed-overflow flags.
module dyt_alu
  import common_types::*;
(
  dyt_alu_if.alu io
);

  localparam int MSB = WORD_W - 1;

  // Operation select and signed overflow for the arithmetic ops.
  always_comb begin
    io.res = '0;
    io.ovf = 1'b0;
    case (io.op)
      ALU_ADD: begin
        io.res = io.a + io.b;
        io.ovf = (io.a[MSB] == io.b[MSB]) && (io.res[MSB] != io.a[MSB]);
      end
      ALU_SUB: begin
        io.res = io.a - io.b;
        io.ovf = (io.a[MSB] != io.b[MSB]) && (io.res[MSB] != io.a[MSB]);
      end
      ALU_AND: io.res = io.a & io.b;
      ALU_OR:  io.res = io.a | io.b;
      ALU_XOR: io.res = io.a ^ io.b;
      default: io.res = '0;
    endcase
  end

  assign io.zero = (io.res == '0);
  assign io.neg  = io.res[MSB];

endmodule

// File: rtl/dyt_alu_arb.sv
// Two-requester round-robin front end for a shared ALU with a one-entry
// registered response slot. One operation per cycle while the consumer
// keeps rsp_ready high.
module dyt_alu_arb
  import common_types::*;
#(
  parameter logic RR_INIT = 1'b0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  aluop_t            req0_op,
  input  logic [WORD_W-1:0] req0_a,
  input  logic [WORD_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  aluop_t            req1_op,
  input  logic [WORD_W-1:0] req1_a,
  input  logic [WORD_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WORD_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_neg,
  output logic              rsp_ovf
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t state;
  logic   ptr;
  logic   can_accept;
  logic   gnt0;
  logic   gnt1;

  dyt_alu_if alu_io ();
  dyt_alu    u_alu (.io(alu_io));

  // Slot can take a new result when empty or when it drains this cycle;
  // nRST gating keeps both readies low throughout reset.
  always_comb begin
    can_accept = nRST && ((state == ST_EMPTY) || rsp_ready);
    gnt0       = can_accept && req0_valid && (!req1_valid || !ptr);
    gnt1       = can_accept && req1_valid && (!req0_valid ||  ptr);
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Operand mux; defaults to requester 0 when nobody is granted.
  always_comb begin
    alu_io.op = gnt1 ? req1_op : req0_op;
    alu_io.a  = gnt1 ? req1_a  : req0_a;
    alu_io.b  = gnt1 ? req1_b  : req0_b;
  end

  // Slot state, priority pointer and the captured ALU result.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= ST_EMPTY;
      ptr      <= RR_INIT;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_neg  <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else begin
      if (gnt0 || gnt1) begin
        state    <= ST_FULL;
        ptr      <= gnt0;
        rsp_id   <= gnt1;
        rsp_data <= alu_io.res;
        rsp_zero <= alu_io.zero;
        rsp_neg  <= alu_io.neg;
        rsp_ovf  <= alu_io.ovf;
      end else if ((state == ST_FULL) && rsp_ready) begin
        state <= ST_EMPTY;
      end
    end
  end

  assign rsp_valid = (state == ST_FULL);

endmodule

// File: tb/tb_dyt_alu_arb.sv
// Directed bench for dyt_alu_arb: accepted requests push hand-computed
// results into a queue, a monitor pops and compares on each response handshake.
module tb_dyt_alu_arb;
  import common_types::*;

  typedef struct packed {
    logic              id;
    logic [WORD_W-1:0] data;
    logic              z;
    logic              n;
    logic              o;
  } exp_t;

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic              req0_ready, req1_ready;
  aluop_t            req0_op = ALU_ADD, req1_op = ALU_ADD;
  logic [WORD_W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic              rsp_valid, rsp_ready = 1'b0, rsp_id;
  logic [WORD_W-1:0] rsp_data;
  logic              rsp_zero, rsp_neg, rsp_ovf;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t cur0, cur1, mon_e;

  dyt_alu_arb #(.RR_INIT(1'b0)) dut (
    .CLK(CLK), .nRST(nRST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg), .rsp_ovf(rsp_ovf)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Pop-and-compare on response handshakes, then record newly accepted requests.
  always @(negedge CLK) begin
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0d data 0x%0h expected no response", rsp_id, rsp_data);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, mon_e.id});
        chk("rsp_data", rsp_data, mon_e.data);
        chk("rsp_flags_zno", {29'd0, rsp_zero, rsp_neg, rsp_ovf}, {29'd0, mon_e.z, mon_e.n, mon_e.o});
      end
    end
    if (req0_valid && req0_ready) sb.push_back(cur0);
    if (req1_valid && req1_ready) sb.push_back(cur1);
  end

  task automatic issue(input bit k, input aluop_t op, input logic [31:0] a, input logic [31:0] b,
                       input exp_t e);
    int n = 0;
    if (!k) begin
      req0_op = op; req0_a = a; req0_b = b; cur0 = e; req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; cur1 = e; req1_valid = 1'b1;
    end
    #1;
    while (!(k ? req1_ready : req0_ready) && n < 20) begin
      cyc();
      n++;
    end
    if (n == 20) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: requester %0d got no ready within 20 cycles, required ready", k);
    end
    cyc();
    if (!k) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  initial begin
    // Reset state, readies held low even with both requesters valid
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #3;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_flags", {29'd0, rsp_zero, rsp_neg, rsp_ovf}, 0);
    cyc();
    cyc();
    chk("rst_readies", {30'd0, req1_ready, req0_ready}, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #2 nRST = 1'b1;
    cyc();

    // rsp_ready while empty does nothing
    rsp_ready = 1'b1;
    cyc();
    cyc();
    chk("idle_rsp_valid", {31'd0, rsp_valid}, 0);

    // ADD 5+7 from requester 0, latency one
    req0_op = ALU_ADD; req0_a = 32'd5; req0_b = 32'd7;
    cur0 = exp_t'{1'b0, 32'd12, 1'b0, 1'b0, 1'b0};
    req0_valid = 1'b1;
    #1;
    chk("add_req0_ready", {31'd0, req0_ready}, 1);
    chk("add_req1_ready", {31'd0, req1_ready}, 0);
    cyc();
    req0_valid = 1'b0;
    chk("add_rsp_valid", {31'd0, rsp_valid}, 1);
    chk("add_rsp_id", {31'd0, rsp_id}, 0);
    chk("add_rsp_data", rsp_data, 12);
    chk("add_rsp_zero", {31'd0, rsp_zero}, 0);

    // Signed overflow on requester 1
    issue(1'b1, ALU_ADD, 32'h7FFF_FFFF, 32'd1, exp_t'{1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1});

    // Both valid: pointer is at 0, grants must alternate 0,1,0,1
    req0_op = ALU_SUB; req0_a = 32'd10;  req0_b = 32'd3;
    req1_op = ALU_OR;  req1_a = 32'hF0;  req1_b = 32'h0F;
    cur0 = exp_t'{1'b0, 32'd7, 1'b0, 1'b0, 1'b0};
    cur1 = exp_t'{1'b1, 32'hFF, 1'b0, 1'b0, 1'b0};
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_gnt0", {31'd0, req0_ready}, (i % 2 == 0) ? 1 : 0);
      chk("rr_gnt1", {31'd0, req1_ready}, (i % 2 == 1) ? 1 : 0);
      cyc();
      chk("rr_rsp_valid", {31'd0, rsp_valid}, 1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Equal-operand SUB sets zero
    issue(1'b0, ALU_SUB, 32'h1234, 32'h1234, exp_t'{1'b0, 32'd0, 1'b1, 1'b0, 1'b0});
    cyc();
    cyc();

    // Backpressure: response frozen, nobody granted, then release grants req1
    rsp_ready = 1'b0;
    issue(1'b0, ALU_AND, 32'hFF, 32'h0F, exp_t'{1'b0, 32'h0F, 1'b0, 1'b0, 1'b0});
    req1_op = ALU_XOR; req1_a = 32'hAA; req1_b = 32'h55;
    cur1 = exp_t'{1'b1, 32'hFF, 1'b0, 1'b0, 1'b0};
    req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_readies", {30'd0, req1_ready, req0_ready}, 0);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 1);
      chk("bp_rsp_data", rsp_data, 32'h0F);
      chk("bp_rsp_id", {31'd0, rsp_id}, 0);
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_req1_ready", {31'd0, req1_ready}, 1);
    cyc();
    req1_valid = 1'b0;
    cyc();
    cyc();

    // Async reset while full drops the held response; RR_INIT wins first after release
    rsp_ready = 1'b0;
    issue(1'b0, ALU_ADD, 32'd1, 32'd2, exp_t'{1'b0, 32'd3, 1'b0, 1'b0, 1'b0});
    chk("pre_rst_full", {31'd0, rsp_valid}, 1);
    #2;
    nRST = 1'b0;
    req0_op = ALU_ADD; req0_a = 32'd2; req0_b = 32'd2;
    req1_op = ALU_ADD; req1_a = 32'd3; req1_b = 32'd3;
    cur0 = exp_t'{1'b0, 32'd4, 1'b0, 1'b0, 1'b0};
    cur1 = exp_t'{1'b1, 32'd6, 1'b0, 1'b0, 1'b0};
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("async_rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("async_rst_rsp_data", rsp_data, 0);
    chk("async_rst_readies", {30'd0, req1_ready, req0_ready}, 0);
    sb.delete();
    cyc();
    chk("in_rst_readies", {30'd0, req1_ready, req0_ready}, 0);
    #2 nRST = 1'b1;
    #1;
    chk("post_rst_gnt0", {31'd0, req0_ready}, 1);
    chk("post_rst_gnt1", {31'd0, req1_ready}, 0);
    cyc();
    chk("post_rst_second_gnt1", {31'd0, req1_ready}, 1);
    chk("post_rst_second_gnt0", {31'd0, req0_ready}, 0);
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    repeat (5) cyc();
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
